// File: rtl/key_step_conditioner_pkg.sv
// rtl/key_step_conditioner_pkg.sv - shared state encodings and defaults for the step-key conditioner
// Purpose: FSM state encoding and the default debounce length used by key_step_conditioner.
// Ports: none (package).
package key_step_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } ks_state_e;

   // 1 ms of stability at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage : key_step_conditioner_pkg

// File: rtl/key_step_conditioner_sync_chain.sv
// rtl/key_step_conditioner_sync_chain.sv - multi-stage flop synchronizer with programmable reset value
// Purpose: brings an asynchronous bus into the clk domain through STAGES flops.
// Ports:
//   clk    in   1      sampling clock
//   rst_n  in   1      asynchronous active-low reset, loads RESET_VALUE into every stage
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronized output (last stage)
module sync_chain #(
   parameter int   WIDTH       = 1,
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_d [STAGES];
   logic [WIDTH-1:0] stage_q [STAGES];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= {WIDTH{RESET_VALUE}};
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule : sync_chain

// File: rtl/key_step_conditioner.sv
// rtl/key_step_conditioner.sv - debounced single-step pulse generator with switch capture
// Purpose: turns the raw active-low step button and slide switches into one clean step
//          pulse per debounced press, plus the switch value captured on that pulse.
// Ports:
//   CLOCK_50     in   1         system clock
//   reset_n      in   1         asynchronous active-low reset
//   key_n        in   1         raw step button, active-low, asynchronous
//   sw_raw       in   SW_WIDTH  raw slide switches, asynchronous
//   step         out  1         one-cycle pulse per accepted press
//   sw_sample    out  SW_WIDTH  synchronized switches latched on the step cycle
//   key_level    out  1         debounced key level, 1 = pressed
//   press_count  out  8         accepted presses, wraps 255->0
module key_step_conditioner
   import key_step_conditioner_pkg::*;
#(
   parameter int SW_WIDTH        = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                CLOCK_50,
   input  logic                reset_n,
   input  logic                key_n,
   input  logic [SW_WIDTH-1:0] sw_raw,
   output logic                step,
   output logic [SW_WIDTH-1:0] sw_sample,
   output logic                key_level,
   output logic [7:0]          press_count
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                k_s;
   logic [SW_WIDTH-1:0] sw_s;

   ks_state_e           state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                step_q, step_d;
   logic [SW_WIDTH-1:0] sw_sample_q, sw_sample_d;
   logic                key_level_q, key_level_d;
   logic [7:0]          press_count_q, press_count_d;

   // Key and switches use identical chain depth so sw_s lines up with k_s.
   sync_chain #(
      .WIDTH       (1),
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (1'b1)
   ) u_key_sync (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .d     (key_n),
      .q     (k_s)
   );

   sync_chain #(
      .WIDTH       (SW_WIDTH),
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (1'b0)
   ) u_sw_sync (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .d     (sw_raw),
      .q     (sw_s)
   );

   // State and output registers
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         step_q        <= 1'b0;
         sw_sample_q   <= '0;
         key_level_q   <= 1'b0;
         press_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         step_q        <= step_d;
         sw_sample_q   <= sw_sample_d;
         key_level_q   <= key_level_d;
         press_count_q <= press_count_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!k_s) state_d = ST_PRESS_WAIT;
         end
         ST_PRESS_WAIT: begin
            if (k_s)                    state_d = ST_IDLE;
            else if (cnt_q == CNT_LAST) state_d = ST_PRESSED;
         end
         ST_PRESSED: begin
            if (k_s) state_d = ST_RELEASE_WAIT;
         end
         ST_RELEASE_WAIT: begin
            if (!k_s)                   state_d = ST_PRESSED;
            else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter and registered outputs
   always_comb begin
      cnt_d         = '0;
      step_d        = 1'b0;
      sw_sample_d   = sw_sample_q;
      press_count_d = press_count_q;
      key_level_d   = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);

      // Count only while staying inside a wait state; any transition restarts at zero.
      if ((state_d == state_q) &&
          ((state_q == ST_PRESS_WAIT) || (state_q == ST_RELEASE_WAIT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // The only path that produces a step is a completed press debounce.
      if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
         step_d        = 1'b1;
         sw_sample_d   = sw_s;
         press_count_d = press_count_q + 8'd1;
      end
   end

   assign step        = step_q;
   assign sw_sample   = sw_sample_q;
   assign key_level   = key_level_q;
   assign press_count = press_count_q;

endmodule : key_step_conditioner

// File: tb/tb_key_step_conditioner.sv
// tb/tb_key_step_conditioner.sv - directed self-checking bench for key_step_conditioner
module tb_key_step_conditioner;

   localparam int SW_W = 10;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            key_n;
   logic [SW_W-1:0] sw_raw;
   logic            step;
   logic [SW_W-1:0] sw_sample;
   logic            key_level;
   logic [7:0]      press_count;

   int n_cmp = 0;
   int n_bad = 0;

   int  cyc           = 0;
   int  step_cnt      = 0;
   int  last_step_cyc = -1;
   int  dbl_cnt       = 0;
   logic prev_step    = 1'b0;

   always #10 clk = ~clk;

   key_step_conditioner #(
      .SW_WIDTH        (SW_W),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .CLOCK_50    (clk),
      .reset_n     (reset_n),
      .key_n       (key_n),
      .sw_raw      (sw_raw),
      .step        (step),
      .sw_sample   (sw_sample),
      .key_level   (key_level),
      .press_count (press_count)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (step === 1'b1) begin
         step_cnt      = step_cnt + 1;
         last_step_cyc = cyc;
         if (prev_step === 1'b1) dbl_cnt = dbl_cnt + 1;
      end
      prev_step = step;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic hold_key(input logic v, input int n);
      key_n = v;
      tick(n);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
   endtask

   int c0, c1, r, f, s, d;

   initial begin
      reset_n = 1'b0;
      key_n   = 1'b1;
      sw_raw  = 10'h155;

      // 1. reset
      tick(2);
      check_eq("rst_step",        32'(step),        32'd0);
      check_eq("rst_sw_sample",   32'(sw_sample),   32'd0);
      check_eq("rst_key_level",   32'(key_level),   32'd0);
      check_eq("rst_press_count", 32'(press_count), 32'd0);
      reset_n = 1'b1;
      tick(3);
      check_eq("post_rst_steps",       32'(step_cnt),    32'd0);
      check_eq("post_rst_sw_sample",   32'(sw_sample),   32'd0);
      check_eq("post_rst_press_count", 32'(press_count), 32'd0);

      // 2. clean press
      sw_raw = 10'h0AA;
      c0 = cyc;
      hold_key(1'b0, 10);
      check_eq("p2_steps",       32'(step_cnt),      32'd1);
      check_eq("p2_step_cycle",  32'(last_step_cyc), 32'(c0 + 7));
      check_eq("p2_sw_sample",   32'(sw_sample),     32'h0AA);
      check_eq("p2_press_count", 32'(press_count),   32'd1);
      check_eq("p2_key_level",   32'(key_level),     32'd1);
      sw_raw = 10'h111;
      r = cyc;
      hold_key(1'b1, 6);
      check_eq("p2_level_hold", 32'(key_level), 32'd1);
      tick(1);
      check_eq("p2_level_drop", 32'(key_level), 32'd0);
      check_eq("p2_sw_hold",    32'(sw_sample), 32'h0AA);
      tick(4);

      // 3. bounce on press
      do_reset();
      s = step_cnt;
      sw_raw = 10'h055;
      hold_key(1'b0, 2);
      hold_key(1'b1, 1);
      f = cyc;
      hold_key(1'b0, 10);
      check_eq("p3_steps",       32'(step_cnt),      32'(s + 1));
      check_eq("p3_step_cycle",  32'(last_step_cyc), 32'(f + 7));
      check_eq("p3_press_count", 32'(press_count),   32'd1);
      check_eq("p3_sw_sample",   32'(sw_sample),     32'h055);
      hold_key(1'b1, 10);

      // 4. glitch
      s = step_cnt;
      sw_raw = 10'h200;
      hold_key(1'b0, 3);
      hold_key(1'b1, 12);
      check_eq("p4_steps",       32'(step_cnt),    32'(s));
      check_eq("p4_press_count", 32'(press_count), 32'd1);
      check_eq("p4_sw_sample",   32'(sw_sample),   32'h055);
      check_eq("p4_key_level",   32'(key_level),   32'd0);

      // 5. release bounce while pressed, then a second clean press
      do_reset();
      sw_raw = 10'h0F0;
      hold_key(1'b0, 8);
      check_eq("p5a_press_count", 32'(press_count), 32'd1);
      check_eq("p5a_key_level",   32'(key_level),   32'd1);
      s = step_cnt;
      hold_key(1'b1, 2);
      hold_key(1'b0, 5);
      check_eq("p5_bounce_level", 32'(key_level), 32'd1);
      hold_key(1'b1, 10);
      check_eq("p5_no_extra_step", 32'(step_cnt),    32'(s));
      check_eq("p5_released",      32'(key_level),   32'd0);
      check_eq("p5_count_held",    32'(press_count), 32'd1);
      sw_raw = 10'h3FF;
      c1 = cyc;
      hold_key(1'b0, 8);
      check_eq("p5b_steps",       32'(step_cnt),      32'(s + 1));
      check_eq("p5b_step_cycle",  32'(last_step_cyc), 32'(c1 + 7));
      check_eq("p5b_sw_sample",   32'(sw_sample),     32'h3FF);
      check_eq("p5b_press_count", 32'(press_count),   32'd2);
      hold_key(1'b1, 10);

      // 6a. reset in PRESS_WAIT with count=2
      hold_key(1'b0, 5);
      reset_n = 1'b0;
      #1;
      check_eq("p6_rst_step",        32'(step),        32'd0);
      check_eq("p6_rst_key_level",   32'(key_level),   32'd0);
      check_eq("p6_rst_press_count", 32'(press_count), 32'd0);
      check_eq("p6_rst_sw_sample",   32'(sw_sample),   32'd0);
      s = step_cnt;
      key_n = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(10);
      check_eq("p6_no_pending_step", 32'(step_cnt), 32'(s));

      // 6b. key already held when reset releases
      reset_n = 1'b0;
      key_n   = 1'b0;
      tick(2);
      d = cyc;
      reset_n = 1'b1;
      tick(10);
      check_eq("p6b_steps",       32'(step_cnt),      32'(s + 1));
      check_eq("p6b_step_cycle",  32'(last_step_cyc), 32'(d + 7));
      check_eq("p6b_press_count", 32'(press_count),   32'd1);
      hold_key(1'b1, 10);

      // 6c. press_count wrap
      do_reset();
      s = step_cnt;
      for (int i = 0; i < 256; i++) begin
         hold_key(1'b0, 8);
         hold_key(1'b1, 9);
         if (i == 254) check_eq("wrap_255", 32'(press_count), 32'd255);
      end
      check_eq("wrap_0",     32'(press_count), 32'd0);
      check_eq("wrap_steps", 32'(step_cnt),    32'(s + 256));
      check_eq("step_width", 32'(dbl_cnt),     32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_key_step_conditioner
